// File: rtl/monitor_pkg.sv
// Shared types and constants for the commit monitor: FSM states, the
// end-of-test instruction encodings and the trace FIFO payload.
package monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DONE_PASS,
        DONE_FAIL,
        TIMEOUT
    } monitorState_t;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cycle;
        logic [31:0] seq;
    } trace_entry_t;

    // ecall and ebreak both terminate the test program
    function automatic logic isEndOfTest(input logic [31:0] inst);
        return (inst == INST_ECALL) || (inst == INST_EBREAK);
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Trace FIFO with a registered head entry; a push into an empty FIFO becomes
// visible on the head one cycle later, never in the same cycle.
module commit_fifo
    import monitor_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  trace_entry_t pushData,
    input  logic         pop,
    output logic         headValid,
    output trace_entry_t headData,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    trace_entry_t mem [DEPTH];
    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic [AW:0]  wrPtrNext;
    logic [AW:0]  rdPtrNext;
    logic         doPush;
    logic         doPop;
    logic         headFromPush;

    // The extra pointer bit tells a full FIFO apart from an empty one
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty = (wrPtr == rdPtr);

    assign doPop  = pop && headValid;
    assign doPush = push && (!full || doPop);

    assign wrPtrNext = doPush ? (wrPtr + PTR_ONE) : wrPtr;
    assign rdPtrNext = doPop  ? (rdPtr + PTR_ONE) : rdPtr;

    // The slot being written this cycle is the next head only when the FIFO drains to it
    assign headFromPush = doPush && (wrPtr[AW-1:0] == rdPtrNext[AW-1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            headValid <= 1'b0;
            headData  <= '0;
        end else begin
            headValid <= (rdPtrNext != wrPtrNext);
            if (rdPtrNext != wrPtrNext) begin
                headData <= headFromPush ? pushData : mem[rdPtrNext[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Watches the core's commit stream: traces every committed instruction,
// grades the test on ecall/ebreak from a0 and flags a stalled core.
module commit_monitor
    import monitor_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_start,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic [31:0] reg_a0,
    input  logic [31:0] mcycle,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_inst,
    output logic [31:0] trace_cycle,
    output logic [31:0] trace_seq,
    output logic        overflow,
    output logic [31:0] commit_count,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    monitorState_t  state;
    monitorState_t  stateNext;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] watchdogNext;
    logic           acceptCommit;
    logic           fifoFull;
    logic           fifoEmpty;
    logic           popNow;
    trace_entry_t   pushEntry;
    trace_entry_t   headEntry;

    assign acceptCommit = (state == RUN) && commit_valid;
    assign popNow       = !fifoEmpty && trace_ready;

    assign pushEntry = '{pc: commit_pc, inst: commit_inst, cycle: mcycle, seq: commit_count};

    commit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) traceFifo (
        .clock     (clock),
        .reset     (reset),
        .push      (acceptCommit),
        .pushData  (pushEntry),
        .pop       (trace_ready),
        .headValid (trace_valid),
        .headData  (headEntry),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    assign trace_pc    = headEntry.pc;
    assign trace_inst  = headEntry.inst;
    assign trace_cycle = headEntry.cycle;
    assign trace_seq   = headEntry.seq;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            watchdog <= '0;
        end else begin
            state    <= stateNext;
            watchdog <= watchdogNext;
        end
    end

    // Terminal states have no exits; only reset leaves them
    always_comb begin
        stateNext    = state;
        watchdogNext = watchdog;
        case (state)
            IDLE: begin
                if (io_in_start) begin
                    stateNext    = RUN;
                    watchdogNext = '0;
                end
            end
            RUN: begin
                if (commit_valid) begin
                    watchdogNext = '0;
                    if (isEndOfTest(commit_inst)) begin
                        stateNext = (reg_a0 == 32'd0) ? DONE_PASS : DONE_FAIL;
                    end
                end else if (watchdog == WD_LAST) begin
                    stateNext = TIMEOUT;
                end else begin
                    watchdogNext = watchdog + WD_ONE;
                end
            end
            default: begin
                stateNext = state;
            end
        endcase
    end

    // A dropped commit still consumes a sequence number
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_count <= '0;
            overflow     <= 1'b0;
        end else begin
            if (acceptCommit) begin
                commit_count <= commit_count + 32'd1;
            end
            if (acceptCommit && fifoFull && !popNow) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            done    <= (stateNext == DONE_PASS) || (stateNext == DONE_FAIL) || (stateNext == TIMEOUT);
            pass    <= (stateNext == DONE_PASS);
            timeout <= (stateNext == TIMEOUT);
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: scenario tasks plus random traffic,
// compared against a queue-based model of the trace and grading rules.
`timescale 1ns/1ps
module tb_commit_monitor;
    import monitor_pkg::*;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_start;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic [31:0] reg_a0;
    logic [31:0] mcycle;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic [31:0] trace_cycle;
    logic [31:0] trace_seq;
    logic        overflow;
    logic [31:0] commit_count;
    logic        done;
    logic        pass;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    trace_entry_t mQueue[$];
    logic [31:0]  mCount;
    logic         mOverflow;
    logic         mRunning;
    logic         mDone;
    logic         mPass;
    logic         mTimeout;
    int           mStall;

    commit_monitor #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_start  (io_in_start),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .reg_a0       (reg_a0),
        .mcycle       (mcycle),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_inst   (trace_inst),
        .trace_cycle  (trace_cycle),
        .trace_seq    (trace_seq),
        .overflow     (overflow),
        .commit_count (commit_count),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] randInst();
        logic [31:0] v;
        v = $urandom;
        if (v == INST_ECALL || v == INST_EBREAK) v = v ^ 32'h0000_1000;
        return v;
    endfunction

    function automatic logic [164:0] observedSnapshot();
        return {trace_valid,
                (trace_valid ? {trace_pc, trace_inst, trace_cycle, trace_seq} : 128'd0),
                overflow, commit_count, done, pass, timeout};
    endfunction

    function automatic logic [164:0] expectedSnapshot();
        trace_entry_t h;
        logic v;
        v = (mQueue.size() != 0);
        h = v ? mQueue[0] : '0;
        return {v, h, mOverflow, mCount, mDone, mPass, mTimeout};
    endfunction

    task automatic modelReset();
        mQueue.delete();
        mCount    = 32'd0;
        mOverflow = 1'b0;
        mRunning  = 1'b0;
        mDone     = 1'b0;
        mPass     = 1'b0;
        mTimeout  = 1'b0;
        mStall    = 0;
    endtask

    task automatic idleInputs();
        io_in_start  = 1'b0;
        commit_valid = 1'b0;
        commit_pc    = 32'd0;
        commit_inst  = 32'd0;
        reg_a0       = 32'd0;
        trace_ready  = 1'b0;
    endtask

    // Advance the model by the edge about to happen, then step the DUT past it
    task automatic applyStimulus();
        trace_entry_t e;
        mcycle = $urandom;
        if (mQueue.size() != 0 && trace_ready) void'(mQueue.pop_front());
        if (mRunning) begin
            if (commit_valid) begin
                e.pc = commit_pc; e.inst = commit_inst; e.cycle = mcycle; e.seq = mCount;
                if (mQueue.size() >= DEPTH) mOverflow = 1'b1;
                else mQueue.push_back(e);
                mCount = mCount + 32'd1;
                mStall = 0;
                if (commit_inst == 32'h0000_0073 || commit_inst == 32'h0010_0073) begin
                    mRunning = 1'b0;
                    mDone    = 1'b1;
                    mPass    = (reg_a0 == 32'd0);
                end
            end else if (mStall == TO - 1) begin
                mRunning = 1'b0;
                mDone    = 1'b1;
                mTimeout = 1'b1;
            end else begin
                mStall = mStall + 1;
            end
        end else if (!mDone && io_in_start) begin
            mRunning = 1'b1;
            mStall   = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        idleInputs();
        #2 reset = 1'b1;
        modelReset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idleInputs();
        mcycle = 32'd0;
        reset  = 1'b1;
        modelReset();
        #8;
        total++;
        if (observedSnapshot() !== 165'd0) begin
            bad++;
            $display("FAIL reset_values: got %h want 0", observedSnapshot());
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic_commits();
        logic [31:0] seenSeq[$];
        logic [31:0] seenPc[$];
        logic [164:0] obsSnap, expSnap;
        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            commit_valid = (i < 3);
            commit_pc    = 32'(i * 4);
            commit_inst  = randInst();
            reg_a0       = $urandom;
            applyStimulus();
            obsSnap = observedSnapshot(); expSnap = expectedSnapshot();
            total++;
            if (obsSnap !== expSnap) begin
                bad++;
                $display("FAIL basic_cycle%0d: got %h want %h", i, obsSnap, expSnap);
            end
            if (trace_valid) begin
                seenSeq.push_back(trace_seq);
                seenPc.push_back(trace_pc);
            end
        end
        total++;
        if (seenSeq.size() != 3) begin
            bad++;
            $display("FAIL basic_entry_count: got %0d want 3", seenSeq.size());
        end
        for (int i = 0; i < seenSeq.size(); i++) begin
            total++;
            if (seenSeq[i] !== 32'(i) || seenPc[i] !== 32'(i * 4)) begin
                bad++;
                $display("FAIL basic_entry%0d: got seq=%0d pc=%h want seq=%0d pc=%h", i, seenSeq[i], seenPc[i], i, i * 4);
            end
        end
        total++;
        if (commit_count !== 32'd3) begin
            bad++;
            $display("FAIL basic_count: got %0d want 3", commit_count);
        end
    endtask

    task automatic test_end_of_test(input string name, input logic [31:0] endInst,
                                    input logic [31:0] a0Val, input logic expectPass);
        logic [164:0] obsSnap, expSnap;
        int foundAt;
        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            commit_valid = 1'b1; commit_pc = 32'h100 + 32'(4 * i);
            commit_inst = randInst(); reg_a0 = $urandom;
            applyStimulus();
        end
        commit_pc = 32'h200; commit_inst = endInst; reg_a0 = a0Val;
        applyStimulus();
        total++;
        if (done !== 1'b1 || pass !== expectPass || timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s_grade: got done=%b pass=%b timeout=%b want done=1 pass=%b timeout=0",
                     name, done, pass, timeout, expectPass);
        end
        for (int i = 0; i < 3; i++) begin
            commit_pc = $urandom; commit_inst = randInst(); reg_a0 = $urandom;
            applyStimulus();
            obsSnap = observedSnapshot(); expSnap = expectedSnapshot();
            total++;
            if (obsSnap !== expSnap) begin
                bad++;
                $display("FAIL %s_after%0d: got %h want %h", name, i, obsSnap, expSnap);
            end
        end
        commit_valid = 1'b0;
        total++;
        if (commit_count !== 32'd3) begin
            bad++;
            $display("FAIL %s_count: got %0d want 3", name, commit_count);
        end
        trace_ready = 1'b1;
        foundAt = -1;
        for (int i = 0; i < 5; i++) begin
            if (trace_valid && trace_inst === endInst && trace_seq === 32'd2 && trace_pc === 32'h200) foundAt = i;
            applyStimulus();
        end
        total++;
        if (foundAt != 2) begin
            bad++;
            $display("FAIL %s_trace_entry: got position %0d want 2", name, foundAt);
        end
    endtask

    task automatic test_timeout();
        logic [164:0] obsSnap, expSnap;
        int hitAt;
        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        hitAt = -1;
        for (int i = 1; i <= 40 && hitAt < 0; i++) begin
            applyStimulus();
            obsSnap = observedSnapshot(); expSnap = expectedSnapshot();
            total++;
            if (obsSnap !== expSnap) begin
                bad++;
                $display("FAIL timeout_cycle%0d: got %h want %h", i, obsSnap, expSnap);
            end
            if (timeout === 1'b1) hitAt = i;
        end
        total++;
        if (hitAt != TO || done !== 1'b1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL timeout_latency: got cycle=%0d done=%b pass=%b want cycle=%0d done=1 pass=0", hitAt, done, pass, TO);
        end

        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        for (int i = 1; i < TO; i++) applyStimulus();
        commit_valid = 1'b1; commit_pc = 32'h40; commit_inst = randInst();
        applyStimulus();
        commit_valid = 1'b0;
        total++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL watchdog_clear: got timeout=%b done=%b want 0 0", timeout, done);
        end
        hitAt = -1;
        for (int i = 1; i <= 40 && hitAt < 0; i++) begin
            applyStimulus();
            if (timeout === 1'b1) hitAt = i;
        end
        total++;
        if (hitAt != TO) begin
            bad++;
            $display("FAIL watchdog_restart: got cycle=%0d want %0d", hitAt, TO);
        end
    endtask

    task automatic test_full_push_pop();
        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        trace_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_valid = 1'b1; commit_pc = 32'(i * 4); commit_inst = randInst();
            applyStimulus();
        end
        trace_ready = 1'b1; commit_pc = 32'h800;
        applyStimulus();
        trace_ready = 1'b0; commit_valid = 1'b0;
        total++;
        if (overflow !== 1'b0 || commit_count !== 32'd9 || trace_valid !== 1'b1 || trace_seq !== 32'd1) begin
            bad++;
            $display("FAIL full_push_pop: got ovf=%b count=%0d valid=%b seq=%0d want ovf=0 count=9 valid=1 seq=1",
                     overflow, commit_count, trace_valid, trace_seq);
        end
        total++;
        if (observedSnapshot() !== expectedSnapshot()) begin
            bad++;
            $display("FAIL full_push_pop_model: got %h want %h", observedSnapshot(), expectedSnapshot());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] seenSeq[$];
        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            commit_valid = 1'b1; commit_pc = 32'(i * 4); commit_inst = randInst();
            applyStimulus();
        end
        commit_valid = 1'b0;
        total++;
        if (overflow !== 1'b1 || commit_count !== 32'd10) begin
            bad++;
            $display("FAIL overflow_flags: got ovf=%b count=%0d want ovf=1 count=10", overflow, commit_count);
        end
        trace_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (trace_valid) seenSeq.push_back(trace_seq);
            applyStimulus();
        end
        total++;
        if (seenSeq.size() != DEPTH) begin
            bad++;
            $display("FAIL overflow_drain_count: got %0d want %0d", seenSeq.size(), DEPTH);
        end
        for (int i = 0; i < seenSeq.size(); i++) begin
            total++;
            if (seenSeq[i] !== 32'(i)) begin
                bad++;
                $display("FAIL overflow_seq%0d: got %0d want %0d", i, seenSeq[i], i);
            end
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            commit_valid = 1'b1; commit_pc = $urandom; commit_inst = randInst();
            applyStimulus();
        end
        commit_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if (trace_valid !== 1'b0 || commit_count !== 32'd0 || overflow !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got valid=%b count=%0d ovf=%b done=%b want all 0",
                     trace_valid, commit_count, overflow, done);
        end
        modelReset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1; commit_pc = $urandom; commit_inst = randInst();
            applyStimulus();
        end
        total++;
        if (commit_count !== 32'd0 || trace_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_needs_start: got count=%0d valid=%b want 0 0", commit_count, trace_valid);
        end
        commit_valid = 1'b0;
        io_in_start = 1'b1; applyStimulus(); io_in_start = 1'b0;
        commit_valid = 1'b1; applyStimulus(); commit_valid = 1'b0;
        total++;
        if (commit_count !== 32'd1 || trace_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_after_reset: got count=%0d valid=%b want 1 1", commit_count, trace_valid);
        end
    endtask

    task automatic test_random();
        logic [164:0] obsSnap, expSnap;
        applyReset();
        for (int i = 0; i < 600; i++) begin
            if (mDone && $urandom_range(0, 19) == 0) applyReset();
            io_in_start  = ($urandom_range(0, 7) == 0);
            commit_valid = $urandom_range(0, 1);
            commit_pc    = $urandom;
            commit_inst  = ($urandom_range(0, 39) == 0) ?
                           (($urandom_range(0, 1) == 0) ? INST_ECALL : INST_EBREAK) : randInst();
            reg_a0       = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            trace_ready  = ($urandom_range(0, 2) == 0);
            applyStimulus();
            obsSnap = observedSnapshot(); expSnap = expectedSnapshot();
            total++;
            if (obsSnap !== expSnap) begin
                bad++;
                $display("FAIL random_step%0d: got %h want %h", i, obsSnap, expSnap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_commits();
        test_end_of_test("ecall_pass", INST_ECALL, 32'd0, 1'b1);
        test_end_of_test("ebreak_fail", INST_EBREAK, 32'd1, 1'b0);
        test_end_of_test("ecall_fail", INST_ECALL, 32'hdead_beef, 1'b0);
        test_timeout();
        test_full_push_pop();
        test_overflow();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL time_limit: got run still active want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Downstream consumer of the core's commit-state outputs (`io_out_state_instState_*`, `regState_10`, `csrState_mcycle`) inside the cocotb bench top. Each committed instruction is captured into a small trace FIFO, which is drained over a valid/ready port. The block detects end-of-test (`ecall`/`ebreak`), grades pass/fail from a0 (x10), and raises a watchdog timeout when commits stall.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: trace FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096: RUN-state cycles without a commit before timeout; ≥2.

Ports:
- `clock`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `io_in_start`  in  1  same start pulse the core receives.
- `commit_valid`  in  1  core `instState_commit`.
- `commit_pc`  in  32  core `instState_pc`.
- `commit_inst`  in  32  core `instState_inst`.
- `reg_a0`  in  32  core `regState_10`.
- `mcycle`  in  32  core `csrState_mcycle`.
- `trace_valid`  out  1  FIFO head valid.
- `trace_ready`  in  1  consumer accepts head.
- `trace_pc`, `trace_inst`, `trace_cycle`  out  32 each  head entry fields.
- `trace_seq`  out  32  commit sequence number of head entry.
- `overflow`  out  1  sticky; a commit was dropped because the FIFO was full.
- `commit_count`  out  32  commits accepted in RUN, wraps at 2^32.
- `done`  out  1  test finished (any terminal state).
- `pass`  out  1  valid when `done`; 1 only in DONE_PASS.
- `timeout`  out  1  1 only in TIMEOUT.

## Operation
- FSM states: IDLE, RUN, DONE_PASS, DONE_FAIL, TIMEOUT. Reset → IDLE.
- IDLE → RUN when `io_in_start`=1.
- RUN, `commit_valid`=1:
  - Push {pc, inst, mcycle, seq=commit_count} into the FIFO.
  - `commit_count` increments.
  - Watchdog clears to 0.
- RUN, `commit_valid`=1 and `commit_inst` ∈ {0x00000073 ecall, 0x00100073 ebreak}:
  - Entry is still pushed.
  - Next state is DONE_PASS if `reg_a0`==0 (sampled in the same cycle), else DONE_FAIL.
- RUN, no commit: watchdog increments. When it equals `TIMEOUT_CYCLES-1` and no commit occurs, next state is TIMEOUT.
- Terminal states are held until reset.
  - Commits are ignored in IDLE and terminal states: no push, no count.
  - The FIFO continues draining in every state.
- FIFO full and push without simultaneous pop: entry dropped, `overflow` set (sticky), `commit_count` still increments.
- Full with push and pop in the same cycle: both take effect, occupancy unchanged, no overflow.
- Empty with push and `trace_ready` in the same cycle: no bypass; the entry appears next cycle.
- Pointer arithmetic is modulo `FIFO_DEPTH`, with an extra wrap bit for full/empty distinction.
- Watchdog width is clog2(`TIMEOUT_CYCLES`)+1.

## Timing
- Reset values: `trace_valid`=0, trace fields=0, `overflow`=0, `commit_count`=0, `done`=0, `pass`=0, `timeout`=0.
- Push to `trace_valid`: 1 cycle. All outputs are registered.
- Pop occurs on the rising edge where `trace_valid`&&`trace_ready`. The head updates the following cycle.
- `done`/`pass`/`timeout` assert 1 cycle after the terminating commit, or after the final watchdog cycle.
- `commit_count` updates 1 cycle after the commit.
- Reset asserted mid-operation: FIFO contents discarded, FSM to IDLE immediately (async). Requires `io_in_start` again.

## Structure
- Package `monitor_pkg`:
  - state enum
  - `INST_ECALL`, `INST_EBREAK` constants
  - `trace_entry_t` struct {pc, inst, cycle, seq}
- Sub-module `commit_fifo` (parameterised depth, `trace_entry_t` payload, registered head, push/pop/full/empty) instantiated once. FSM, counters and grading live in `commit_monitor`.

## Test plan
- Reset, start, 3 commits (pc 0x0/0x4/0x8), `trace_ready`=1 → 3 entries with seq 0,1,2 in order; `commit_count`=3.
- Commit `inst`=0x00000073 with `reg_a0`=0 → `done`=1, `pass`=1 next cycle; ecall entry present in trace; later commits not counted.
- Same with `reg_a0`=1 → `done`=1, `pass`=0, `timeout`=0.
- `TIMEOUT_CYCLES`=16, start, no commits → `timeout`=1 and `done`=1 exactly 16 cycles after entering RUN. A commit at cycle 15 instead resets the watchdog.
- `FIFO_DEPTH`=8, `trace_ready`=0, 10 commits → 8 entries (seq 0–7), `overflow`=1, `commit_count`=10. Full with simultaneous push/pop → no new overflow.
- Async reset mid-RUN with FIFO non-empty → `trace_valid`=0 and counters 0 before the next clock edge; commits ignored until `io_in_start`.
